// File: rtl/ddr_pkg.sv
// Shared definitions for the cache-line to LPDDR burst bridge: state encoding,
// line/beat geometry and the line byte-reversal used on both data paths.
package ddr_pkg;

   localparam int LINE_BYTES = 16;
   localparam int BEATS      = 4;
   localparam int LINE_W     = LINE_BYTES * 8;
   localparam int BEAT_W     = LINE_W / BEATS;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_DATA,
      ST_WR_CMD,
      ST_RD_CMD,
      ST_RD_DATA,
      ST_DONE,
      ST_RELEASE
   } state_t;

   // Cache byte i <-> DDR byte 15-i; beats are packed {beat3, beat2, beat1, beat0}.
   // The mapping is its own inverse, so reads and writes share it.
   function automatic logic [LINE_W-1:0] line_byterev(input logic [LINE_W-1:0] v);
      logic [LINE_W-1:0] r;
      for (int i = 0; i < LINE_BYTES; i++) begin
         r[8*i +: 8] = v[8*(LINE_BYTES-1-i) +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/ddr_line_bridge_if.sv
// Cache-side line request bus plus the LPDDR controller user interface,
// grouped so the bridge and its environment connect through one handle.
interface ddr_line_bridge_if #(
   parameter int ADDR_W = 21
);
   logic [ADDR_W-1:0]         mem_addr;
   logic [ddr_pkg::LINE_W-1:0] mem_wdata;
   logic                      mem_wstrb;
   logic                      mem_valid;
   logic [ddr_pkg::LINE_W-1:0] mem_rdata;
   logic                      mem_ready;
   logic                      phy_init_done;
   logic [ADDR_W+1:0]         app_addr;
   logic                      app_cmd;
   logic                      app_en;
   logic                      app_rdy;
   logic [ddr_pkg::BEAT_W-1:0] app_wdf_data;
   logic                      app_wdf_wren;
   logic                      app_wdf_rdy;
   logic [ddr_pkg::BEAT_W-1:0] app_rd_data;
   logic                      app_rd_data_valid;
   logic                      busy;
   logic                      err;

   modport slave (
      input  mem_addr, mem_wdata, mem_wstrb, mem_valid, phy_init_done,
             app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
      output mem_rdata, mem_ready, app_addr, app_cmd, app_en,
             app_wdf_data, app_wdf_wren, busy, err
   );

   modport master (
      output mem_addr, mem_wdata, mem_wstrb, mem_valid, phy_init_done,
             app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid,
      input  mem_rdata, mem_ready, app_addr, app_cmd, app_en,
             app_wdf_data, app_wdf_wren, busy, err
   );
endinterface

// File: rtl/line_byteswap.sv
// Combinational 128-bit line <-> 4x32-bit beat mapper (full 16-byte reversal).
module line_byteswap
   import ddr_pkg::*;
(
   input  logic [LINE_W-1:0] din_i,
   output logic [LINE_W-1:0] dout_o
);
   assign dout_o = line_byterev(din_i);
endmodule

// File: rtl/ddr_line_bridge.sv
// Converts each 128-bit cache line request into one burst-of-4 transaction on the
// 32-bit LPDDR controller user interface; traffic is held off until calibration.
//
// state      | meaning
// IDLE       | waiting for mem_valid with phy_init_done
// WR_DATA    | pushing write beats, one per app_wdf_rdy accept
// WR_CMD     | write command offered until app_rdy
// RD_CMD     | read command offered until app_rdy
// RD_DATA    | collecting four read beats
// DONE       | one-cycle mem_ready
// RELEASE    | waiting for the cache to drop mem_valid
module ddr_line_bridge
   import ddr_pkg::*;
#(
   parameter int ADDR_W = 21
) (
   input logic              clk,
   input logic              rst_n,
   ddr_line_bridge_if.slave bus
);

   state_t              state_q, state_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [LINE_W-1:0]   wbeats_q, wbeats_d;
   logic [3*BEAT_W-1:0] rbuf_q, rbuf_d;
   logic [LINE_W-1:0]   mem_rdata_q, mem_rdata_d;
   logic [ADDR_W+1:0]   app_addr_q, app_addr_d;
   logic [BEAT_W-1:0]   wdf_data_q, wdf_data_d;
   logic                app_en_q, app_en_d;
   logic                app_cmd_q, app_cmd_d;
   logic                wren_q, wren_d;
   logic                ready_q, ready_d;
   logic                busy_q, busy_d;
   logic                err_q, err_d;
   logic [LINE_W-1:0]   wr_beats, rd_line;

   line_byteswap u_wr_swap (.din_i(bus.mem_wdata), .dout_o(wr_beats));
   line_byteswap u_rd_swap (.din_i({bus.app_rd_data, rbuf_q}), .dout_o(rd_line));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wbeats_d    = wbeats_q;
      rbuf_d      = rbuf_q;
      mem_rdata_d = mem_rdata_q;
      app_addr_d  = app_addr_q;
      err_d       = err_q | (bus.app_rd_data_valid && (state_q != ST_RD_DATA));

      case (state_q)
         ST_IDLE: begin
            if (bus.mem_valid && bus.phy_init_done) begin
               app_addr_d = {bus.mem_addr, 2'b00};
               wbeats_d   = wr_beats;
               cnt_d      = 2'd0;
               state_d    = bus.mem_wstrb ? ST_WR_DATA : ST_RD_CMD;
            end
         end
         ST_WR_DATA: begin
            if (wren_q && bus.app_wdf_rdy) begin
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_d = ST_WR_CMD;
            end
         end
         ST_WR_CMD: if (app_en_q && bus.app_rdy) state_d = ST_DONE;
         ST_RD_CMD: if (app_en_q && bus.app_rdy) state_d = ST_RD_DATA;
         ST_RD_DATA: begin
            if (bus.app_rd_data_valid) begin
               cnt_d = cnt_q + 2'd1;
               case (cnt_q)
                  2'd0:    rbuf_d[BEAT_W-1:0]          = bus.app_rd_data;
                  2'd1:    rbuf_d[2*BEAT_W-1:BEAT_W]   = bus.app_rd_data;
                  2'd2:    rbuf_d[3*BEAT_W-1:2*BEAT_W] = bus.app_rd_data;
                  default: begin
                     // last beat bypasses the buffer straight into the line
                     mem_rdata_d = rd_line;
                     state_d     = ST_DONE;
                  end
               endcase
            end
         end
         ST_DONE:    state_d = ST_RELEASE;
         ST_RELEASE: if (!bus.mem_valid) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase

      // Outputs are computed from the next state so every port comes from a flop.
      app_en_d   = (state_d == ST_WR_CMD) || (state_d == ST_RD_CMD);
      app_cmd_d  = (state_d != ST_WR_CMD);
      wren_d     = (state_d == ST_WR_DATA);
      wdf_data_d = wren_d ? wbeats_d[{cnt_d, 5'b0} +: BEAT_W] : wdf_data_q;
      ready_d    = (state_d == ST_DONE);
      busy_d     = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 2'd0;
         wbeats_q    <= '0;
         rbuf_q      <= '0;
         mem_rdata_q <= '0;
         app_addr_q  <= '0;
         wdf_data_q  <= '0;
         app_en_q    <= 1'b0;
         app_cmd_q   <= 1'b1;
         wren_q      <= 1'b0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wbeats_q    <= wbeats_d;
         rbuf_q      <= rbuf_d;
         mem_rdata_q <= mem_rdata_d;
         app_addr_q  <= app_addr_d;
         wdf_data_q  <= wdf_data_d;
         app_en_q    <= app_en_d;
         app_cmd_q   <= app_cmd_d;
         wren_q      <= wren_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

   assign bus.mem_rdata    = mem_rdata_q;
   assign bus.mem_ready    = ready_q;
   assign bus.app_addr     = app_addr_q;
   assign bus.app_cmd      = app_cmd_q;
   assign bus.app_en       = app_en_q;
   assign bus.app_wdf_data = wdf_data_q;
   assign bus.app_wdf_wren = wren_q;
   assign bus.busy         = busy_q;
   assign bus.err          = err_q;

endmodule
